// File: rtl/upsample_control_unit.sv
// Address/write-enable sequencer for 2x nearest-neighbour upsampling: LOAD sweep, then 2x2 block writes.
// Optional build macro UPSAMPLE_DONE_HOLD_EN keeps done high in IDLE until the next accepted start.
module upsample_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  size_upsample,
  output logic        done,
  output logic [3:0]  write_mode,
  output logic        en_write_in,
  output logic        en_write_out,
  output logic [13:0] addr_input,
  output logic [13:0] addr_output
);

  typedef enum logic [1:0] {IDLE, LOAD, UPS, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [13:0] cnt_q, cnt_d;
  logic [3:0]  lg;
  logic [14:0] load_last, ups_last;

  logic        done_d;
  logic [3:0]  wm_d;
  logic        en_in_d, en_out_d;
  logic [13:0] ain_d, aout_d;
  logic [11:0] pix, row, col;
  logic [13:0] row2, col2;

  // Size tracks the clamped input while idle, so the bounds are already right in the start cycle.
  always_comb begin
    size_d  = size_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) size_d = (size_upsample > 3'd4) ? 3'd4 : size_upsample;
    lg        = {1'b0, size_d} + 4'd2;
    load_last = (15'd1 << {lg, 1'b0}) - 15'd1;
    ups_last  = (15'd1 << ({lg, 1'b0} + 5'd2)) - 15'd1;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if ({1'b0, cnt_q} == load_last) begin
        state_d = UPS;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 14'd1;
      end
      UPS: if ({1'b0, cnt_q} == ups_last) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 14'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state/count so they can be registered without a cycle of lag.
  always_comb begin
    done_d   = 1'b0;
    wm_d     = '0;
    en_in_d  = 1'b0;
    en_out_d = 1'b0;
    ain_d    = '0;
    aout_d   = '0;
    pix      = cnt_d[13:2];
    row      = pix >> lg;
    col      = pix & ((12'd1 << lg) - 12'd1);
    row2     = {1'b0, row, cnt_d[1]};
    col2     = {1'b0, col, cnt_d[0]};
    case (state_d)
      LOAD: begin
        en_in_d = 1'b1;
        ain_d   = cnt_d;
      end
      UPS: begin
        en_out_d = 1'b1;
        ain_d    = {2'b00, pix};
        aout_d   = (row2 << (lg + 4'd1)) | col2;
        wm_d     = 4'b0001 << cnt_d[1:0];
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
`ifdef UPSAMPLE_DONE_HOLD_EN
    if (state_d == IDLE && done) done_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      size_q       <= '0;
      cnt_q        <= '0;
      done         <= 1'b0;
      write_mode   <= '0;
      en_write_in  <= 1'b0;
      en_write_out <= 1'b0;
      addr_input   <= '0;
      addr_output  <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      done         <= done_d;
      write_mode   <= wm_d;
      en_write_in  <= en_in_d;
      en_write_out <= en_out_d;
      addr_input   <= ain_d;
      addr_output  <= aout_d;
    end
  end

endmodule

// File: tb/tb_upsample_control_unit.sv
// Directed bench for upsample_control_unit: cycle-exact output vectors against a reference model and hand values.
module tb_upsample_control_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  size_upsample;
  logic        done;
  logic [3:0]  write_mode;
  logic        en_write_in;
  logic        en_write_out;
  logic [13:0] addr_input;
  logic [13:0] addr_output;
  logic [34:0] obs;

  int n_cmp = 0;
  int n_err = 0;
  bit done_idle = 1'b0;

`ifdef UPSAMPLE_DONE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  upsample_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .size_upsample(size_upsample),
    .done         (done),
    .write_mode   (write_mode),
    .en_write_in  (en_write_in),
    .en_write_out (en_write_out),
    .addr_input   (addr_input),
    .addr_output  (addr_output)
  );

  assign obs = {done, write_mode, en_write_in, en_write_out, addr_input, addr_output};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] mk(input int d, input int wm, input int ei, input int eo,
                                     input int ai, input int ao);
    return {1'(d), 4'(wm), 1'(ei), 1'(eo), 14'(ai), 14'(ao)};
  endfunction

  // Reference: expected output vector in cycle i after the start edge, for side n.
  function automatic logic [34:0] model(input int n, input int i, input bit dn_idle);
    int n2, j, p, q, r, c;
    n2 = n * n;
    if (i >= 1 && i <= n2) return mk(0, 0, 1, 0, i - 1, 0);
    if (i > n2 && i <= 5 * n2) begin
      j = i - n2 - 1;
      p = j / 4;
      q = j % 4;
      r = p / n;
      c = p % n;
      return mk(0, 1 << q, 0, 1, p, (2 * r + q / 2) * 2 * n + 2 * c + q % 2);
    end
    if (i == 5 * n2 + 1) return mk(1, 0, 0, 0, 0, 0);
    return mk(int'(dn_idle), 0, 0, 0, 0, 0);
  endfunction

  function automatic bit hand_lookup(input int n, input int i, output logic [34:0] v);
    v = '0;
    hand_lookup = 1'b1;
    if (n == 4) begin
      case (i)
        1:       v = mk(0, 0, 1, 0, 0, 0);
        16:      v = mk(0, 0, 1, 0, 15, 0);
        17:      v = mk(0, 1, 0, 1, 0, 0);
        18:      v = mk(0, 2, 0, 1, 0, 1);
        19:      v = mk(0, 4, 0, 1, 0, 8);
        20:      v = mk(0, 8, 0, 1, 0, 9);
        77:      v = mk(0, 1, 0, 1, 15, 54);
        78:      v = mk(0, 2, 0, 1, 15, 55);
        79:      v = mk(0, 4, 0, 1, 15, 62);
        80:      v = mk(0, 8, 0, 1, 15, 63);
        81:      v = mk(1, 0, 0, 0, 0, 0);
        default: hand_lookup = 1'b0;
      endcase
    end else if (n == 8) begin
      case (i)
        65:      v = mk(0, 1, 0, 1, 0, 0);
        321:     v = mk(1, 0, 0, 0, 0, 0);
        default: hand_lookup = 1'b0;
      endcase
    end else if (n == 64) begin
      case (i)
        4096:    v = mk(0, 0, 1, 0, 4095, 0);
        20480:   v = mk(0, 8, 0, 1, 4095, 16383);
        20481:   v = mk(1, 0, 0, 0, 0, 0);
        default: hand_lookup = 1'b0;
      endcase
    end else begin
      hand_lookup = 1'b0;
    end
  endfunction

  task automatic idle_chk(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk("idle", obs, mk(int'(done_idle), 0, 0, 0, 0, 0));
    end
  endtask

  // One run from an idle negedge; noise toggles start/size during the run.
  task automatic run_seq(input logic [2:0] sz, input int n, input bit noise);
    int last;
    logic [34:0] hv;
    last = 5 * n * n + 1;
    size_upsample = sz;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      chk($sformatf("run_s%0d_c%0d", sz, i), obs, model(n, i, done_idle));
      if (hand_lookup(n, i, hv)) chk($sformatf("hand_n%0d_c%0d", n, i), obs, hv);
      if (noise && i < last) begin
        start = 1'($urandom_range(0, 1));
        size_upsample = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
    end
    size_upsample = sz;
    done_idle = HOLD;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    size_upsample = 3'd0;
    #3;
    chk("reset_t0", obs, '0);
    start = 1'b1;
    @(negedge clk);
    chk("reset_start_ignored", obs, '0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle_chk(2);

    run_seq(3'd0, 4, 1'b0);
    idle_chk(3);

    // Continuous start: second run's LOAD begins two cycles after done.
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 163; i++) begin
      @(negedge clk);
      if (i <= 82) chk($sformatf("cont_c%0d", i), obs, model(4, i, HOLD));
      else chk($sformatf("cont_c%0d", i), obs, model(4, i - 82, HOLD));
      if (i >= 83) start = 1'b0;
    end
    done_idle = HOLD;
    idle_chk(2);

    run_seq(3'd4, 64, 1'b0);
    idle_chk(2);
    run_seq(3'd7, 64, 1'b1);
    idle_chk(2);

    // Asynchronous reset in the middle of UPS.
    size_upsample = 3'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 74; i++) begin
      @(negedge clk);
      chk($sformatf("abort_c%0d", i), obs, model(8, i, 1'b0));
    end
    #2 rst = 1'b0;
    #1 chk("rst_async", obs, '0);
    done_idle = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_held", obs, '0);
    end
    rst = 1'b1;
    idle_chk(3);
    run_seq(3'd1, 8, 1'b0);
    idle_chk(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/upsample_control_unit.md
# upsample_control_unit

Address and write-enable sequencer for the 2x nearest-neighbour upsampling stage of the generator datapath. On `start` it first sweeps the input feature-map buffer for loading, then reads each input pixel and writes it to the four positions of the corresponding 2x2 block in the output buffer. It drives only addresses, enables and a one-hot sub-position code. Pixel data moves between the buffers outside this block.

## Interface
- No parameters. Sizes come from `size_upsample` at run time.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a run; sampled only in IDLE.
- `size_upsample` input 3: input map side N = 4 << size_upsample (0→4, 1→8, 2→16, 3→32, 4→64); values 5–7 are treated as 4.
- `done` output 1: run-complete indication.
- `write_mode` output 4: one-hot 2x2 sub-position being written (bit0 top-left, bit1 top-right, bit2 bottom-left, bit3 bottom-right); 0 otherwise.
- `en_write_in` output 1: input-buffer write enable (LOAD phase).
- `en_write_out` output 1: output-buffer write enable (UPS phase).
- `addr_input` output 14: input-buffer address (write in LOAD, read in UPS).
- `addr_output` output 14: output-buffer write address.

## Operation
- States:
  - IDLE: waits for `start`=1, then latches the clamped size and goes to LOAD.
  - LOAD: runs N² cycles with `en_write_in`=1 and `addr_input`=0..N²−1 ascending, then goes to UPS.
  - UPS: runs 4·N² cycles, then goes to DONE.
  - DONE: lasts 1 cycle with `done`=1, then returns to IDLE.
- UPS ordering: input pixels go in raster order (r,c), r,c in 0..N−1. Each pixel takes 4 consecutive cycles, q = 0..3.
  - `addr_input` = r·N + c, held for all 4 cycles.
  - `addr_output` = (2r + q[1])·2N + 2c + q[0].
  - `write_mode` = 1 << q.
  - `en_write_out` = 1.
- Outputs not named for a state are 0 in that state.
- Addresses are unsigned and zero-extended to 14 bits. The maximum output address is 16383 (N=64) and never wraps.
- `start` in LOAD, UPS or DONE is ignored. A `size_upsample` change mid-run has no effect.
- All outputs are registered and glitch-free.

## Timing
- Reset (async assert, any state): go to IDLE immediately. `done`, `write_mode`, `en_write_in`, `en_write_out`, `addr_input`, `addr_output` are all 0.
- Reset deassertion: first `start` is sampled at the next rising edge.
- With `start` sampled high at edge k:
  - LOAD outputs are valid for cycles k+1..k+N².
  - UPS outputs are valid for cycles k+N²+1..k+5N².
  - `done` is high in cycle k+5N²+1.
- Total latency from start to done: 5N²+1 cycles. Size 0 gives 81 cycles; size 4 gives 20481 cycles.
- A new `start` is accepted in the cycle after DONE. `start` held high continuously restarts immediately after each run.
- Reset asserted mid-run aborts the run without asserting `done`.

## Configuration
- `UPSAMPLE_DONE_HOLD_EN` defined: `done` rises on the DONE state and stays high in IDLE until the next accepted `start` or reset. It clears in the cycle LOAD begins.
- `UPSAMPLE_DONE_HOLD_EN` undefined (default): `done` is a single-cycle pulse.
- State sequence and all other outputs are identical in both builds.

## Test plan
- Reset, then size 0 with a 1-cycle `start` pulse:
  - `en_write_in` is high for 16 cycles with `addr_input` 0..15.
  - Then 64 cycles of `en_write_out`.
  - `done` pulses 81 cycles after start; all outputs are 0 afterwards.
- Size 0, first UPS pixel:
  - `addr_output` = 0, 1, 8, 9 with `write_mode` = 1, 2, 4, 8, and `addr_input` = 0.
  - Pixel (3,3) gives `addr_output` 54, 55, 62, 63 with `addr_input` 15.
- Size 4: the last UPS cycle shows `addr_input`=4095, `addr_output`=16383, `write_mode`=8; `done` occurs at cycle 20481.
- Size 7: the sequence is identical to size 4. Toggling `start` and `size_upsample` mid-run has no effect.
- Assert `rst` during UPS: all outputs drop to 0 without waiting for a clock, and `done` is never asserted. After release, a new `start` at size 1 runs a full 321-cycle sequence.
- With `UPSAMPLE_DONE_HOLD_EN`: `done` stays 1 after a size-0 run until the next `start`, then clears as LOAD begins.
